fetch: RTL
==========

Name: fetch

Overview:
- Instruction fetch stage. Produces the PC, instruction word, exception and valid signals that the decode stage consumes.
- Issues one request at a time on a valid/ready instruction-memory port and holds or buffers the response while decode is stalled.
- On flush, redirects the PC and discards any in-flight response.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INSTR_W, 32, instruction width.
- EX_W, 4, exception code width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EX_INSTR_MISALIGNED, 4'd0, code reported for PC[1:0] != 0.
- EX_INSTR_ACCESS_FAULT, 4'd1, code reported when the memory response carries an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  request strobe
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  ADDR_W  fetch address (= pc)
- imem_rsp_valid  in  1  response strobe; always accepted, no backpressure
- imem_rsp_data  in  INSTR_W  instruction word
- imem_rsp_error  in  1  access fault on this response
- stall  in  1  downstream hold
- flush  in  1  redirect request
- redirect_pc  in  ADDR_W  new PC, sampled when flush=1
- PC_out  out  ADDR_W  PC of the issued instruction
- instr_out  out  INSTR_W  instruction word
- exception_out  out  EX_W  exception code
- exception_out_valid  out  1  exception present
- pipeline_out_valid  out  1  outputs hold a valid instruction

Behaviour:
- Reset: pc=RESET_PC, state=REQ, hold buffer empty.
- Reset output values: PC_out=0, instr_out=0, exception_out=0, exception_out_valid=0, pipeline_out_valid=0, imem_req_valid=0 during the reset cycle.
- Reset has priority over every other input and aborts any state.
- States:
  - REQ:
    - imem_req_valid=1 when pc[1:0]==0. On valid&&ready -> WAIT.
    - If pc[1:0]!=0, no request is issued. Instead, when stall=0, output: pipeline_out_valid=1, PC_out=pc, instr_out=0, exception_out=EX_INSTR_MISALIGNED, exception_out_valid=1. Then go to HALT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - stall=0: load outputs, pc<=pc+4, -> REQ.
    - stall=1: capture into the hold buffer -> HOLD.
  - HOLD: outputs frozen. When stall falls, move the buffer to the outputs, pc<=pc+4, -> REQ.
  - DRAIN: a request is outstanding after a flush. Discard the next imem_rsp_valid (no output, pc unchanged) -> REQ.
  - HALT: after an exception is issued. pipeline_out_valid=0 and no further requests until flush.
- Loading the outputs: PC_out<=pc, instr_out<=rsp_data, pipeline_out_valid<=1.
  - If rsp_error=1: exception_out<=EX_INSTR_ACCESS_FAULT, exception_out_valid<=1, state -> HALT instead of REQ.
  - Otherwise exception_out_valid<=0.
- Output register rules:
  - When stall=1, all outputs hold their value, regardless of state.
  - When stall=0 and nothing new is loaded this cycle, pipeline_out_valid<=0. Other outputs hold.
- Flush (any state except reset):
  - pc<=redirect_pc, pipeline_out_valid<=0, hold buffer cleared.
  - Next state: DRAIN if a request is outstanding and its response has not arrived this cycle; otherwise REQ.
  - A request handshake completing in the flush cycle counts as outstanding -> DRAIN.
  - A response arriving in the flush cycle is discarded.
  - flush overrides stall.
- At most one outstanding request. The address is stable while imem_req_valid=1 and ready=0.
- pc+4 wraps modulo 2^ADDR_W, with no exception.
- Latency: a request accepted in cycle N with the response in cycle N+k puts pipeline_out_valid=1 at cycle N+k+1. Minimum issue interval is 2 cycles per instruction.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds output ports fetch_count (32-bit) and fetch_wait_cycles (32-bit). Both are reset to 0 and wrap on overflow.
  - fetch_count increments on each instruction loaded into the outputs, excluding discarded responses.
  - fetch_wait_cycles increments on every cycle spent in WAIT or DRAIN.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, ready=1, 1-cycle response latency with data 0x00000013, 0x00500093 -> outputs (PC_out=0x0, instr_out=0x13), then (0x4, 0x00500093). pipeline_out_valid is a 1-cycle pulse each. Requests go to addr 0x0, 0x4, 0x8.
- Response 0x00A00113 arrives with stall=1 held 3 cycles -> outputs frozen, no new request. Issued at PC 0x8 on the cycle after stall falls; next request addr 0xC.
- Request at 0x10 accepted; flush=1 with redirect_pc=0x100 before the response -> stale response 0xDEADBEEF is dropped with no pipeline_out_valid. Next request addr 0x100.
- flush with redirect_pc=0x102 -> no imem request. Output PC_out=0x102, exception_out=EX_INSTR_MISALIGNED, exception_out_valid=1. Then HALT until the next flush.
- Response at pc 0x20 with rsp_error=1 -> exception_out=EX_INSTR_ACCESS_FAULT, valid=1. No request to 0x24.
- reset asserted in WAIT with a response arriving the same cycle -> all outputs 0. The next request is at RESET_PC and the response is ignored.

Source files
------------

// File: rtl/fetch.sv
// fetch - instruction fetch stage.
//
// Issues one request at a time on a valid/ready instruction-memory port.
// It registers the response into the decode-facing outputs. If decode is
// stalled when the response arrives, the response is parked in a
// one-entry hold buffer. A flush redirects the PC. Any response still in
// flight for the old stream is drained and dropped.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds the fetch_count and fetch_wait_cycles counters as
//   output ports.
//
// Ports:
//   clk                  clock
//   reset                synchronous, active-high reset
//   imem_req_valid       request strobe (only when pc is word aligned)
//   imem_req_ready       memory accepts the request
//   imem_req_addr        fetch address (always equal to pc)
//   imem_rsp_valid       response strobe, never back-pressured
//   imem_rsp_data        instruction word of the response
//   imem_rsp_error       access fault flagged on the response
//   stall                decode hold; freezes all decode-facing outputs
//   flush                redirect request, overrides stall
//   redirect_pc          new PC, sampled when flush=1
//   PC_out               PC of the issued instruction
//   instr_out            issued instruction word
//   exception_out        exception code
//   exception_out_valid  exception present
//   pipeline_out_valid   outputs hold a valid instruction
//   fetch_count          (FETCH_PERF_CNT_EN) instructions loaded into outputs
//   fetch_wait_cycles    (FETCH_PERF_CNT_EN) cycles spent in WAIT or DRAIN
module fetch #(
  parameter int unsigned       ADDR_W                = 32,
  parameter int unsigned       INSTR_W               = 32,
  parameter int unsigned       EX_W                  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC              = '0,
  parameter logic [EX_W-1:0]   EX_INSTR_MISALIGNED   = EX_W'(0),
  parameter logic [EX_W-1:0]   EX_INSTR_ACCESS_FAULT = EX_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_error,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [EX_W-1:0]    exception_out,
  output logic               exception_out_valid,
  output logic               pipeline_out_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        fetch_wait_cycles
`endif
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               hold_error;

  logic               misaligned;
  logic               req_fire;
  logic               outstanding;
  logic               rsp_load;
  logic [INSTR_W-1:0] load_instr;
  logic               load_error;

  assign misaligned     = pc[1:0] != 2'b00;
  // Request is gated by reset so nothing is presented during a reset cycle.
  assign imem_req_valid = !reset && (state == S_REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A flush must drain if a request is still owed a response.
  // That covers a handshake that completes in the flush cycle itself.
  // It also covers a wait whose response has not shown up in that cycle.
  assign outstanding = (state == S_REQ && req_fire) ||
                       ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid);

  // Source of an output load: the live response in WAIT, or the parked
  // response in HOLD, in both cases only once decode is not stalled.
  always_comb begin
    rsp_load   = 1'b0;
    load_instr = imem_rsp_data;
    load_error = imem_rsp_error;
    if (!stall) begin
      if (state == S_WAIT && imem_rsp_valid) begin
        rsp_load = 1'b1;
      end else if (state == S_HOLD) begin
        rsp_load   = 1'b1;
        load_instr = hold_instr;
        load_error = hold_error;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_REQ;
      pc                  <= RESET_PC;
      hold_instr          <= '0;
      hold_error          <= 1'b0;
      PC_out              <= '0;
      instr_out           <= '0;
      exception_out       <= '0;
      exception_out_valid <= 1'b0;
      pipeline_out_valid  <= 1'b0;
    end else if (flush) begin
      pc                 <= redirect_pc;
      pipeline_out_valid <= 1'b0;
      hold_instr         <= '0;
      hold_error         <= 1'b0;
      state              <= outstanding ? S_DRAIN : S_REQ;
    end else begin
      // The valid flag is a one-cycle pulse unless decode holds it.
      if (!stall) begin
        pipeline_out_valid <= 1'b0;
      end
      if (rsp_load) begin
        PC_out             <= pc;
        instr_out          <= load_instr;
        pipeline_out_valid <= 1'b1;
        pc                 <= pc + ADDR_W'(4);
        if (load_error) begin
          exception_out       <= EX_INSTR_ACCESS_FAULT;
          exception_out_valid <= 1'b1;
          state               <= S_HALT;
        end else begin
          exception_out_valid <= 1'b0;
          state               <= S_REQ;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (misaligned) begin
              if (!stall) begin
                PC_out              <= pc;
                instr_out           <= '0;
                exception_out       <= EX_INSTR_MISALIGNED;
                exception_out_valid <= 1'b1;
                pipeline_out_valid  <= 1'b1;
                state               <= S_HALT;
              end
            end else if (req_fire) begin
              state <= S_WAIT;
            end
          end
          // Reaching here with a response means decode is stalled.
          S_WAIT: begin
            if (imem_rsp_valid) begin
              hold_instr <= imem_rsp_data;
              hold_error <= imem_rsp_error;
              state      <= S_HOLD;
            end
          end
          S_DRAIN: begin
            if (imem_rsp_valid) begin
              state <= S_REQ;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Only responses that actually reach the outputs are counted.
  // Responses dropped by a flush are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count       <= '0;
      fetch_wait_cycles <= '0;
    end else begin
      if (rsp_load && !flush) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (state == S_WAIT || state == S_DRAIN) begin
        fetch_wait_cycles <= fetch_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
